// File: rtl/mips_console_pkg.sv
// Shared constants for the MIPS console port and its channel FIFOs.
package mips_console_pkg;
    localparam int CHAR_W_DEF = 8;
    localparam logic [7:0] CHAR_TERM = 8'h00;
endpackage

// File: rtl/mips_console_port_if.sv
// Store port and character stream of the console port, bundled.
//
// Handshake: the device raises out_valid with out_char/out_ch. A character
// transfers on a rising clk edge where out_valid && out_ready. While
// out_valid && !out_ready the device holds out_char/out_ch stable and never
// drops out_valid (reset excepted). Stores need no handshake: wr_en is a
// one-cycle strobe, and wr_full shows which channels would drop it.
interface mips_console_port_if
    import mips_console_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CHAR_W = CHAR_W_DEF
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [CHAR_W-1:0] wr_data;
    logic [NUM_CH-1:0] wr_full;
    logic              out_valid;
    logic              out_ready;
    logic [CHAR_W-1:0] out_char;
    logic [CH_W-1:0]   out_ch;

    modport master (
        output wr_en, wr_ch, wr_data, out_ready,
        input  wr_full, out_valid, out_char, out_ch
    );

    modport slave (
        input  wr_en, wr_ch, wr_data, out_ready,
        output wr_full, out_valid, out_char, out_ch
    );
endinterface

// File: rtl/mips_console_port_fifo.sv
// Per-channel character FIFO with binary pointers and an occupancy count.
// term_pending marks that a terminator sits in the FIFO and has not been popped.
module console_fifo
    import mips_console_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int CHAR_W = CHAR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [CHAR_W-1:0] din,
    input  logic              pop,
    output logic [CHAR_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              term_pending
);
    localparam int AW = $clog2(DEPTH);

    logic [CHAR_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array: written on an accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, count and terminator flag; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            term_pending <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (do_push && din == CHAR_W'(CHAR_TERM)) begin
                term_pending <= 1'b1;
            end else if (do_pop && dout == CHAR_W'(CHAR_TERM)) begin
                term_pending <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/mips_console_port.sv
// Multi-channel console output: per-channel FIFOs drained round-robin into
// one registered character stream, with per-channel done and overflow flags.
module mips_console_port
    import mips_console_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 8,
    parameter int CHAR_W = CHAR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    mips_console_port_if.slave   bus,
    output logic [NUM_CH-1:0]    ch_done,
    output logic                 done,
    output logic                 overflow
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] term_q;
    logic [CHAR_W-1:0] fifo_dout [NUM_CH];

    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   sel;
    logic [CHAR_W-1:0] sel_char;
    logic              sel_found;
    logic              load;
    logic              over_hit;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        console_fifo #(.DEPTH(DEPTH), .CHAR_W(CHAR_W)) u_fifo (
            .clk          (clk),
            .rst          (rst),
            .push         (push[g]),
            .din          (bus.wr_data),
            .pop          (pop[g]),
            .dout         (fifo_dout[g]),
            .full         (fifo_full[g]),
            .empty        (fifo_empty[g]),
            .term_pending (term_q[g])
        );
    end

    assign bus.wr_full = fifo_full;
    assign done        = &ch_done;
    assign load        = !bus.out_valid || bus.out_ready;

    // Store decode: closed channels drop silently, full channels flag overflow.
    always_comb begin
        push     = '0;
        over_hit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.wr_en && bus.wr_ch == CH_W'(i) && !ch_done[i] && !term_q[i]) begin
                if (fifo_full[i]) begin
                    over_hit = 1'b1;
                end else begin
                    push[i] = 1'b1;
                end
            end
        end
    end

    // Round-robin pick: first non-empty channel after the last one served.
    always_comb begin
        int idx;
        sel       = '0;
        sel_char  = '0;
        sel_found = 1'b0;
        pop       = '0;
        for (int off = 1; off <= NUM_CH; off++) begin
            idx = (int'(rr_ptr) + off) % NUM_CH;
            if (!sel_found && !fifo_empty[idx]) begin
                sel_found = 1'b1;
                sel       = CH_W'(idx);
                sel_char  = fifo_dout[idx];
            end
        end
        if (load && sel_found) begin
            pop[sel] = 1'b1;
        end
    end

    // Output register, arbiter pointer and sticky status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_char  <= '0;
            bus.out_ch    <= '0;
            rr_ptr        <= CH_W'(NUM_CH - 1);
            ch_done       <= '0;
            overflow      <= 1'b0;
        end else begin
            if (load) begin
                bus.out_valid <= sel_found;
                if (sel_found) begin
                    bus.out_char <= sel_char;
                    bus.out_ch   <= sel;
                    rr_ptr       <= sel;
                end
            end
            if (bus.out_valid && bus.out_ready && bus.out_char == CHAR_W'(CHAR_TERM)) begin
                ch_done[bus.out_ch] <= 1'b1;
            end
            if (over_hit) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mips_console_port.sv
// Directed bench for mips_console_port with NUM_CH=2, DEPTH=4.
module tb_mips_console_port;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0] ch_done;
    logic       done;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    int cyc;

    logic [8:0] exp_q[$];

    mips_console_port_if #(.NUM_CH(2), .CHAR_W(8)) bus ();

    mips_console_port #(.NUM_CH(2), .DEPTH(4), .CHAR_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ch_done  (ch_done),
        .done     (done),
        .overflow (overflow)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic ch, input logic [7:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_ch   = ch;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Accept characters with out_ready high until exp_q is empty or budget ends.
    task automatic drain(input string tag, input int budget, output int n);
        logic [8:0] e;
        n = 0;
        bus.out_ready = 1'b1;
        while (exp_q.size() > 0 && n < budget) begin
            if (bus.out_valid) begin
                e = exp_q.pop_front();
                check(tag, {23'd0, bus.out_ch, bus.out_char}, {23'd0, e});
            end
            tick();
            n++;
        end
        check({tag, "_left"}, exp_q.size(), 0);
        check({tag, "_idle"}, bus.out_valid, 0);
    endtask

    initial begin
        bus.wr_en     = 1'b0;
        bus.wr_ch     = 1'b0;
        bus.wr_data   = 8'h00;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // reset values
        check("rst_valid", bus.out_valid, 0);
        check("rst_char", bus.out_char, 0);
        check("rst_ch", bus.out_ch, 0);
        check("rst_full", bus.wr_full, 0);
        check("rst_ch_done", ch_done, 0);
        check("rst_done", done, 0);
        check("rst_ovf", overflow, 0);

        // 1: single char, one-cycle latency, single transfer
        bus.out_ready = 1'b1;
        store(1'b0, 8'h48);
        check("t1_not_yet", bus.out_valid, 0);
        tick();
        check("t1_valid", bus.out_valid, 1);
        check("t1_char", bus.out_char, 8'h48);
        check("t1_ch", bus.out_ch, 0);
        tick();
        check("t1_once", bus.out_valid, 0);

        // 2: round-robin interleave
        bus.out_ready = 1'b0;
        store(1'b0, 8'h41);
        store(1'b0, 8'h42);
        store(1'b1, 8'h43);
        store(1'b1, 8'h44);
        exp_q = '{ {1'b0, 8'h41}, {1'b1, 8'h43}, {1'b0, 8'h42}, {1'b1, 8'h44} };
        drain("t2", 20, cyc);
        check("t2_cycles", cyc, 4);

        // 3: backpressure holds the presented char
        bus.out_ready = 1'b0;
        store(1'b0, 8'h58);
        store(1'b0, 8'h59);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", bus.out_valid, 1);
            check("t3_hold_char", bus.out_char, 8'h58);
            tick();
        end
        exp_q = '{ {1'b0, 8'h58}, {1'b0, 8'h59} };
        drain("t3", 20, cyc);
        check("t3_cycles", cyc, 2);

        // 4: fill ch0 behind a stalled ch1 char, fifth store overflows
        bus.out_ready = 1'b0;
        store(1'b1, 8'h2a);
        store(1'b0, 8'h31);
        store(1'b0, 8'h32);
        store(1'b0, 8'h33);
        check("t4_not_full", bus.wr_full, 2'b00);
        store(1'b0, 8'h34);
        check("t4_full", bus.wr_full, 2'b01);
        check("t4_no_ovf", overflow, 0);
        store(1'b0, 8'h35);
        check("t4_ovf", overflow, 1);
        exp_q = '{ {1'b1, 8'h2a}, {1'b0, 8'h31}, {1'b0, 8'h32}, {1'b0, 8'h33}, {1'b0, 8'h34} };
        drain("t4", 20, cyc);
        check("t4_ovf_sticky", overflow, 1);
        check("t4_full_clear", bus.wr_full, 2'b00);

        // 5: terminators, drop after terminator, done
        do_reset();
        check("t5_ovf_rst", overflow, 0);
        bus.out_ready = 1'b0;
        store(1'b0, 8'h61);
        store(1'b0, 8'h00);
        store(1'b0, 8'h7a);
        store(1'b1, 8'h00);
        check("t5_ovf", overflow, 0);
        check("t5_a_char", bus.out_char, 8'h61);
        bus.out_ready = 1'b1;
        tick();
        check("t5_t1_char", bus.out_char, 8'h00);
        check("t5_t1_ch", bus.out_ch, 1);
        check("t5_done0", ch_done, 2'b00);
        tick();
        check("t5_t0_char", bus.out_char, 8'h00);
        check("t5_t0_ch", bus.out_ch, 0);
        check("t5_done1", ch_done, 2'b10);
        check("t5_all_no", done, 0);
        tick();
        check("t5_done2", ch_done, 2'b11);
        check("t5_all", done, 1);
        check("t5_no_z", bus.out_valid, 0);
        store(1'b0, 8'h77);
        tick();
        check("t5_after_done", bus.out_valid, 0);
        check("t5_ovf_end", overflow, 0);

        // 6: mid-operation reset, then fresh char
        do_reset();
        bus.out_ready = 1'b0;
        store(1'b0, 8'h70);
        store(1'b0, 8'h71);
        store(1'b0, 8'h72);
        check("t6_pre_valid", bus.out_valid, 1);
        do_reset();
        check("t6_valid", bus.out_valid, 0);
        check("t6_char", bus.out_char, 0);
        check("t6_ch", bus.out_ch, 0);
        check("t6_full", bus.wr_full, 0);
        check("t6_ch_done", ch_done, 0);
        check("t6_done", done, 0);
        check("t6_ovf", overflow, 0);
        bus.out_ready = 1'b1;
        store(1'b1, 8'h51);
        check("t6_q_lat", bus.out_valid, 0);
        tick();
        check("t6_q_valid", bus.out_valid, 1);
        check("t6_q_char", bus.out_char, 8'h51);
        check("t6_q_ch", bus.out_ch, 1);
        tick();
        check("t6_empty", bus.out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
